// File: rtl/spike_event_buffer_if.sv
// Readout handshake between the spike event buffer and its consumer.
// The master presents the head timestamp and the slave pulls it with out_ready.
interface spike_event_buffer_if #(
    parameter int TS_W = 8
);
    logic            out_valid;
    logic            out_ready;
    logic [TS_W-1:0] out_data;

    modport master (output out_valid, output out_data, input out_ready);
    modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/spike_event_buffer.sv
// Timestamps spike rising edges into a show-ahead FIFO and reports the
// number of spikes seen in each completed window of enabled cycles.
module spike_event_buffer #(
    parameter int DEPTH  = 8,
    parameter int TS_W   = 8,
    parameter int WINDOW = 256,
    parameter int RATE_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic                     spike,
    input  logic                     clear,
    spike_event_buffer_if.master     ob,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [RATE_W-1:0]        rate,
    output logic                     rate_valid
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int WIN_W = $clog2(WINDOW);
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);
    localparam logic [WIN_W-1:0]  WIN_LAST = WIN_W'(WINDOW - 1);
    localparam logic [RATE_W-1:0] ACC_MAX  = '1;

    logic [TS_W-1:0]   mem_q [DEPTH];
    logic [TS_W-1:0]   mem_d [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [TS_W-1:0]   ts_cnt_q, ts_cnt_d;
    logic [WIN_W-1:0]  win_cnt_q, win_cnt_d;
    logic [RATE_W-1:0] acc_q, acc_d, acc_inc;
    logic [RATE_W-1:0] rate_q, rate_d;
    logic              rate_valid_q, rate_valid_d;
    logic              overflow_q, overflow_d;
    logic              spike_d_q, spike_d_d;
    logic              spike_edge, full, pop, push;

    assign spike_edge = spike & ~spike_d_q & en;
    assign full       = (count_q == FULL_CNT);
    assign pop        = ob.out_valid & ob.out_ready;
    assign push       = spike_edge & (~full | pop);
    // Dropped edges still count toward the rate.
    assign acc_inc    = (spike_edge && acc_q != ACC_MAX) ? acc_q + RATE_W'(1) : acc_q;

    always_comb begin
        mem_d        = mem_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q;
        ts_cnt_d     = ts_cnt_q;
        win_cnt_d    = win_cnt_q;
        acc_d        = acc_q;
        rate_d       = rate_q;
        rate_valid_d = 1'b0;
        overflow_d   = overflow_q;
        spike_d_d    = spike;
        if (clear) begin
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            ts_cnt_d   = '0;
            win_cnt_d  = '0;
            acc_d      = '0;
            overflow_d = 1'b0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = ts_cnt_q;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop)
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push && !pop)
                count_d = count_q + CNT_W'(1);
            else if (pop && !push)
                count_d = count_q - CNT_W'(1);
            if (spike_edge && full && !pop)
                overflow_d = 1'b1;
            if (en) begin
                ts_cnt_d = ts_cnt_q + TS_W'(1);
                if (win_cnt_q == WIN_LAST) begin
                    rate_d       = acc_inc;
                    rate_valid_d = 1'b1;
                    acc_d        = '0;
                    win_cnt_d    = '0;
                end else begin
                    win_cnt_d = win_cnt_q + WIN_W'(1);
                    acc_d     = acc_inc;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q        <= '{default: '0};
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            ts_cnt_q     <= '0;
            win_cnt_q    <= '0;
            acc_q        <= '0;
            rate_q       <= '0;
            rate_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
            spike_d_q    <= 1'b0;
        end else begin
            mem_q        <= mem_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            ts_cnt_q     <= ts_cnt_d;
            win_cnt_q    <= win_cnt_d;
            acc_q        <= acc_d;
            rate_q       <= rate_d;
            rate_valid_q <= rate_valid_d;
            overflow_q   <= overflow_d;
            spike_d_q    <= spike_d_d;
        end
    end

    assign ob.out_valid = (count_q != '0);
    assign ob.out_data  = mem_q[rd_ptr_q];
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign rate         = rate_q;
    assign rate_valid   = rate_valid_q;
endmodule

// File: tb/tb_spike_event_buffer.sv
// Directed bench: dut0 uses a 16-cycle rate window, dut1 a 1024-cycle window
// for the rate saturation case; both share the same stimulus.
module tb_spike_event_buffer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic en = 1'b0;
    logic spike = 1'b0;
    logic clear = 1'b0;
    logic out_ready = 1'b0;

    logic [3:0] count0, count1;
    logic       ovf0, ovf1, rv0, rv1;
    logic [7:0] rate0, rate1;

    int n_checks = 0;
    int n_fail = 0;

    spike_event_buffer_if #(.TS_W(8)) ob0 ();
    spike_event_buffer_if #(.TS_W(8)) ob1 ();
    assign ob0.out_ready = out_ready;
    assign ob1.out_ready = out_ready;

    spike_event_buffer #(.DEPTH(8), .TS_W(8), .WINDOW(16), .RATE_W(8)) dut0 (
        .clk(clk), .reset(reset), .en(en), .spike(spike), .clear(clear),
        .ob(ob0), .count(count0), .overflow(ovf0), .rate(rate0), .rate_valid(rv0));

    spike_event_buffer #(.DEPTH(8), .TS_W(8), .WINDOW(1024), .RATE_W(8)) dut1 (
        .clk(clk), .reset(reset), .en(en), .spike(spike), .clear(clear),
        .ob(ob1), .count(count1), .overflow(ovf1), .rate(rate1), .rate_valid(rv1));

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_clear();
        clear = 1'b1;
        spike = 1'b0;
        out_ready = 1'b0;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        logic [7:0] exp_q[$];
        int ecnt;
        logic exp_pulse;
        int waited;
        logic seen;

        #12;
        check_eq("rst_valid", ob0.out_valid, 0);
        check_eq("rst_data", ob0.out_data, 0);
        check_eq("rst_count", count0, 0);
        check_eq("rst_ovf", ovf0, 0);
        check_eq("rst_rate", rate0, 0);
        check_eq("rst_rv", rv0, 0);
        reset = 1'b0;
        en = 1'b1;

        // single spike held 3 cycles at ts 5
        tick_n(5);
        spike = 1'b1;
        tick();
        check_eq("single_valid", ob0.out_valid, 1);
        check_eq("single_data", ob0.out_data, 5);
        check_eq("single_count", count0, 1);
        tick_n(2);
        spike = 1'b0;
        tick();
        check_eq("single_no_second", count0, 1);

        // fill with edges at 10..26, last one dropped
        do_clear();
        check_eq("clr_count", count0, 0);
        tick_n(10);
        for (int i = 0; i < 9; i++) begin
            spike = 1'b1; tick();
            spike = 1'b0; tick();
        end
        check_eq("fill_count", count0, 8);
        check_eq("fill_ovf", ovf0, 1);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check_eq("fill_drain", ob0.out_data, 10 + 2 * i);
            tick();
        end
        out_ready = 1'b0;
        check_eq("fill_empty", ob0.out_valid, 0);
        check_eq("fill_ovf_sticky", ovf0, 1);

        // full FIFO, push at ts 40 together with a pop
        do_clear();
        for (int i = 0; i < 8; i++) begin
            spike = 1'b1; tick();
            spike = 1'b0; tick();
        end
        tick_n(24);
        spike = 1'b1;
        out_ready = 1'b1;
        tick();
        spike = 1'b0;
        out_ready = 1'b0;
        check_eq("pp_count", count0, 8);
        check_eq("pp_ovf", ovf0, 0);
        exp_q = '{8'd2, 8'd4, 8'd6, 8'd8, 8'd10, 8'd12, 8'd14, 8'd40};
        out_ready = 1'b1;
        foreach (exp_q[i]) begin
            check_eq("pp_drain", ob0.out_data, exp_q[i]);
            tick();
        end
        out_ready = 1'b0;
        check_eq("pp_empty", count0, 0);

        // timestamp wrap: 254 then 2
        do_clear();
        tick_n(254);
        spike = 1'b1; tick();
        spike = 1'b0; tick_n(3);
        spike = 1'b1; tick();
        spike = 1'b0;
        check_eq("wrap_count", count0, 2);
        check_eq("wrap_first", ob0.out_data, 254);
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        check_eq("wrap_second", ob0.out_data, 2);
        out_ready = 1'b1; tick(); out_ready = 1'b0;

        // rate window of 16 with a disabled stretch in window 2
        do_clear();
        ecnt = 0;
        for (int c = 0; c < 36; c++) begin
            en = !(c >= 20 && c <= 23);
            spike = (c == 2 || c == 4 || c == 6);
            exp_pulse = en && (ecnt == 15 || ecnt == 31);
            tick();
            check_eq("rate_pulse", rv0, exp_pulse);
            if (exp_pulse) check_eq("rate_value", rate0, (ecnt == 15) ? 3 : 0);
            if (en) ecnt++;
        end
        en = 1'b1;
        spike = 1'b0;

        // clear with 4 queued, overflow set and an edge in the same cycle
        do_clear();
        for (int t = 0; t < 18; t++) begin
            spike = (t % 2 == 0) && (t <= 16);
            tick();
            if (t == 15) begin
                check_eq("mid_rate_rv", rv0, 1);
                check_eq("mid_rate", rate0, 8);
            end
        end
        spike = 1'b0;
        check_eq("mid_count8", count0, 8);
        check_eq("mid_ovf", ovf0, 1);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_eq("mid_drain", ob0.out_data, 2 * i);
            tick();
        end
        check_eq("mid_count4", count0, 4);
        clear = 1'b1;
        spike = 1'b1;
        tick();
        clear = 1'b0;
        spike = 1'b0;
        out_ready = 1'b0;
        check_eq("clr_count0", count0, 0);
        check_eq("clr_ovf0", ovf0, 0);
        check_eq("clr_valid0", ob0.out_valid, 0);
        check_eq("clr_rate_hold", rate0, 8);
        check_eq("clr_rv0", rv0, 0);
        tick();
        spike = 1'b1;
        tick();
        spike = 1'b0;
        check_eq("pre_rst_count", count0, 1);

        // asynchronous reset in the middle of a cycle
        #2;
        reset = 1'b1;
        #1;
        check_eq("arst_valid", ob0.out_valid, 0);
        check_eq("arst_data", ob0.out_data, 0);
        check_eq("arst_count", count0, 0);
        check_eq("arst_ovf", ovf0, 0);
        check_eq("arst_rate", rate0, 0);
        check_eq("arst_rv", rv0, 0);
        tick();
        reset = 1'b0;

        // 300 edges in a 1024-cycle window saturate rate at 255
        for (int i = 0; i < 600; i++) begin
            spike = (i % 2 == 0);
            tick();
        end
        spike = 1'b0;
        waited = 600;
        seen = 1'b0;
        for (int k = 0; k < 600 && !seen; k++) begin
            tick();
            waited++;
            if (rv1) seen = 1'b1;
        end
        check_eq("sat_seen", seen, 1);
        check_eq("sat_cycle", waited, 1024);
        check_eq("sat_rate", rate1, 255);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
